// File: rtl/dragster_configurator_if.sv
// SPI pin bundle between the Dragster configurator and the two line-scan sensors.
// Ports: miso (sensor -> master, reserved), mosi, sclk, ss_n[1:0] (master -> sensors).
// The master modport belongs to the configurator; the slave modport represents the sensor side.
interface dragster_configurator_if;
    logic       miso;
    logic       mosi;
    logic       sclk;
    logic [1:0] ss_n;

    modport master (
        input  miso,
        output mosi,
        output sclk,
        output ss_n
    );

    modport slave (
        output miso,
        input  mosi,
        input  sclk,
        input  ss_n
    );
endinterface

// File: rtl/dragster_configurator.sv
// Power-up configurator: writes a fixed 4-entry register table to sensor 0, then sensor 1, over SPI mode 0.
// Ports: clk, reset_n (asynchronous, active-high despite the name), spi (master modport: mosi, sclk, ss_n out; miso unused).
// Latency: first ss_n fall at the STARTUP_DELAY+1'th edge after reset release; no backpressure, the sequence free-runs, then parks.
module dragster_configurator #(
    parameter int CLK_DIVIDER   = 4,
    parameter int STARTUP_DELAY = 16,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dragster_configurator_if.master spi
);

    // One shared phase counter serves every timed state, so size it for the longest one.
    localparam int MAX_SG = (STARTUP_DELAY > GAP_CYCLES) ? STARTUP_DELAY : GAP_CYCLES;
    localparam int MAX_V  = (MAX_SG > CLK_DIVIDER) ? MAX_SG : CLK_DIVIDER;
    localparam int CW     = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIVIDER - 1);
    localparam logic [CW-1:0] START_LAST = CW'(STARTUP_DELAY - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_LOAD,
        ST_SETUP,
        ST_SCLK_HIGH,
        ST_SCLK_LOW,
        ST_GAP,
        ST_DONE
    } state_t;

    // Frame = {write bit 0, 7-bit address, 8-bit data}.
    function automatic logic [15:0] table_word(input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = {1'b0, 7'h01, 8'h1F};
            2'd1:    w = {1'b0, 7'h02, 8'h00};
            2'd2:    w = {1'b0, 7'h03, 8'h04};
            default: w = {1'b0, 7'h00, 8'h01};
        endcase
        return w;
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [1:0]    tbl_idx, tbl_idx_nxt;
    logic          sensor, sensor_nxt;
    logic [15:0]   shreg, shreg_nxt;
    logic          sclk_q, sclk_nxt;
    logic [1:0]    ss_n_q, ss_n_nxt;

    logic unused_miso;
    assign unused_miso = spi.miso;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state   <= ST_STARTUP;
            cnt     <= '0;
            bit_cnt <= '0;
            tbl_idx <= '0;
            sensor  <= 1'b0;
            shreg   <= '0;
            sclk_q  <= 1'b0;
            ss_n_q  <= 2'b11;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            tbl_idx <= tbl_idx_nxt;
            sensor  <= sensor_nxt;
            shreg   <= shreg_nxt;
            sclk_q  <= sclk_nxt;
            ss_n_q  <= ss_n_nxt;
        end
    end

    // Output registers are updated on the transition into a state, so the pins
    // reflect the new state from the very edge that enters it.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_cnt_nxt = bit_cnt;
        tbl_idx_nxt = tbl_idx;
        sensor_nxt  = sensor;
        shreg_nxt   = shreg;
        sclk_nxt    = sclk_q;
        ss_n_nxt    = ss_n_q;

        case (state)
            ST_STARTUP: begin
                if (cnt == START_LAST) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_LOAD: begin
                shreg_nxt   = table_word(tbl_idx);
                ss_n_nxt    = sensor ? 2'b01 : 2'b10;
                bit_cnt_nxt = '0;
                cnt_nxt     = '0;
                state_nxt   = ST_SETUP;
            end

            ST_SETUP: begin
                if (cnt == DIV_LAST) begin
                    state_nxt = ST_SCLK_HIGH;
                    sclk_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_SCLK_HIGH: begin
                if (cnt == DIV_LAST) begin
                    // Falling sclk and the next mosi bit leave on the same edge.
                    state_nxt = ST_SCLK_LOW;
                    sclk_nxt  = 1'b0;
                    shreg_nxt = {shreg[14:0], 1'b0};
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_SCLK_LOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (bit_cnt == 4'd15) begin
                        state_nxt = ST_GAP;
                        ss_n_nxt  = 2'b11;
                        shreg_nxt = '0;
                    end else begin
                        state_nxt   = ST_SCLK_HIGH;
                        sclk_nxt    = 1'b1;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (sensor && (tbl_idx == 2'd3)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt   = ST_LOAD;
                        tbl_idx_nxt = tbl_idx + 2'd1;
                        if (tbl_idx == 2'd3) begin
                            sensor_nxt = 1'b1;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_DONE: begin
                sclk_nxt  = 1'b0;
                ss_n_nxt  = 2'b11;
                shreg_nxt = '0;
            end

            default: begin
                state_nxt = ST_DONE;
                sclk_nxt  = 1'b0;
                ss_n_nxt  = 2'b11;
                shreg_nxt = '0;
            end
        endcase
    end

    assign spi.mosi = shreg[15];
    assign spi.sclk = sclk_q;
    assign spi.ss_n = ss_n_q;

endmodule

// File: tb/tb_dragster_configurator.sv
module tb_dragster_configurator;

    logic clk;
    logic reset_n;

    dragster_configurator_if spi_if ();

    dragster_configurator #(
        .CLK_DIVIDER  (4),
        .STARTUP_DELAY(16),
        .GAP_CYCLES   (16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .spi    (spi_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_tbl [4];

    // SPI slave monitor, sampling on the falling clk edge.
    logic [15:0] fr_word   [$];
    int          fr_sensor [$];
    int          fr_rises  [$];
    int          fr_low    [$];
    int          gaps      [$];
    logic [15:0] cur_word  = '0;
    int          cur_rises = 0;
    int          cur_low   = 0;
    int          cur_sensor = 0;
    int          gap_cnt   = 0;
    bit          seen_frame = 0;
    int          both_low  = 0;
    int          idle_err  = 0;
    int          mosi_err  = 0;
    logic [1:0]  prev_ss   = 2'b11;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (spi_if.ss_n != 2'b11 && prev_ss == 2'b11) begin
            cur_word   = '0;
            cur_rises  = 0;
            cur_low    = 0;
            cur_sensor = (spi_if.ss_n == 2'b01) ? 1 : 0;
            if (seen_frame) gaps.push_back(gap_cnt);
        end
        if (spi_if.ss_n == 2'b00) both_low++;
        if (spi_if.ss_n != 2'b11) begin
            cur_low++;
            if (spi_if.sclk && !prev_sclk) begin
                cur_word = {cur_word[14:0], spi_if.mosi};
                cur_rises++;
            end
        end else begin
            if (spi_if.sclk !== 1'b0 || spi_if.mosi !== 1'b0) idle_err++;
            gap_cnt++;
        end
        if (spi_if.sclk && (spi_if.mosi !== prev_mosi)) mosi_err++;
        if (spi_if.ss_n == 2'b11 && prev_ss != 2'b11) begin
            fr_word.push_back(cur_word);
            fr_sensor.push_back(cur_sensor);
            fr_rises.push_back(cur_rises);
            fr_low.push_back(cur_low);
            seen_frame = 1;
            gap_cnt    = 1;
        end
        prev_ss   = spi_if.ss_n;
        prev_sclk = spi_if.sclk;
        prev_mosi = spi_if.mosi;
    end

    task automatic clear_monitor();
        fr_word.delete();
        fr_sensor.delete();
        fr_rises.delete();
        fr_low.delete();
        gaps.delete();
        seen_frame = 0;
        both_low   = 0;
        idle_err   = 0;
        mosi_err   = 0;
    endtask

    task automatic test_reset();
        spi_if.miso = 1'b0;
        reset_n     = 1'b1;
        #1;
        n_checks++;
        if ({spi_if.sclk, spi_if.mosi, spi_if.ss_n} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_async: sclk/mosi/ss_n=%b required 0011", {spi_if.sclk, spi_if.mosi, spi_if.ss_n});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({spi_if.sclk, spi_if.mosi, spi_if.ss_n} !== 4'b0011) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: sclk/mosi/ss_n=%b required 0011", i, {spi_if.sclk, spi_if.mosi, spi_if.ss_n});
            end
        end
    endtask

    // Release on a falling edge; the select must drop on the 17th rising edge after release.
    task automatic release_and_check_startup(input string tag);
        int fall_at;
        @(negedge clk);
        clear_monitor();
        reset_n = 1'b0;
        fall_at = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (spi_if.ss_n[0] == 1'b0) begin
                fall_at = n;
                break;
            end
        end
        n_checks++;
        if (fall_at != 17) begin
            n_fail++;
            $display("FAIL %s_ss0_fall: fell after %0d edges, required 17", tag, fall_at);
        end
        n_checks++;
        if (spi_if.ss_n[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ss1_idle: ss_n[1]=%b required 1", tag, spi_if.ss_n[1]);
        end
    endtask

    task automatic test_startup();
        release_and_check_startup("startup");
    endtask

    task automatic test_frames();
        for (int c = 0; c < 2500 && fr_word.size() < 8; c++) @(negedge clk);
        n_checks++;
        if (fr_word.size() != 8) begin
            n_fail++;
            $display("FAIL frame_count: got %0d frames, required 8", fr_word.size());
        end
        for (int i = 0; i < fr_word.size() && i < 8; i++) begin
            n_checks++;
            if (fr_word[i] !== exp_tbl[i % 4]) begin
                n_fail++;
                $display("FAIL frame%0d_word: got %h required %h", i, fr_word[i], exp_tbl[i % 4]);
            end
            n_checks++;
            if (fr_sensor[i] != i / 4) begin
                n_fail++;
                $display("FAIL frame%0d_sensor: got %0d required %0d", i, fr_sensor[i], i / 4);
            end
            n_checks++;
            if (fr_rises[i] != 16) begin
                n_fail++;
                $display("FAIL frame%0d_rises: got %0d required 16", i, fr_rises[i]);
            end
            n_checks++;
            if (fr_low[i] != 132) begin
                n_fail++;
                $display("FAIL frame%0d_ss_low: got %0d cycles required 132", i, fr_low[i]);
            end
        end
        n_checks++;
        if (gaps.size() != 7) begin
            n_fail++;
            $display("FAIL gap_count: got %0d gaps required 7", gaps.size());
        end
        foreach (gaps[i]) begin
            n_checks++;
            if (gaps[i] != 17) begin
                n_fail++;
                $display("FAIL gap%0d_len: got %0d cycles required 17", i, gaps[i]);
            end
        end
        n_checks++;
        if (both_low != 0) begin
            n_fail++;
            $display("FAIL ss_both_low: seen %0d cycles required 0", both_low);
        end
        n_checks++;
        if (mosi_err != 0) begin
            n_fail++;
            $display("FAIL mosi_stable: %0d changes while sclk high, required 0", mosi_err);
        end
        n_checks++;
        if (idle_err != 0) begin
            n_fail++;
            $display("FAIL idle_pins: %0d cycles with sclk/mosi active while deselected, required 0", idle_err);
        end
    endtask

    task automatic test_done();
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            spi_if.miso = 1'($urandom_range(0, 1));
            if ({spi_if.sclk, spi_if.mosi, spi_if.ss_n} !== 4'b0011) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL done_idle: %0d non-idle cycles, required 0", bad);
        end
        n_checks++;
        if (fr_word.size() != 8) begin
            n_fail++;
            $display("FAIL done_no_frames: frame count %0d required 8", fr_word.size());
        end
    endtask

    task automatic test_midframe_reset();
        bit hit;
        hit = 0;
        // Third frame reached once two complete frames are logged.
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (fr_word.size() == 2 && spi_if.ss_n == 2'b10 && cur_rises == 7 && spi_if.sclk) begin
                hit = 1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midframe_reach: bit 7 of frame 3 not reached, required reached");
        end
        #2;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({spi_if.sclk, spi_if.mosi, spi_if.ss_n} !== 4'b0011) begin
            n_fail++;
            $display("FAIL midframe_async: sclk/mosi/ss_n=%b required 0011", {spi_if.sclk, spi_if.mosi, spi_if.ss_n});
        end
        repeat (5) @(negedge clk);
        release_and_check_startup("restart");
        for (int c = 0; c < 400 && fr_word.size() < 1; c++) @(negedge clk);
        n_checks++;
        if (fr_word.size() < 1) begin
            n_fail++;
            $display("FAIL restart_frame: no frame after restart, required 1");
        end else begin
            n_checks++;
            if (fr_word[0] !== 16'h011F || fr_sensor[0] != 0 || fr_rises[0] != 16) begin
                n_fail++;
                $display("FAIL restart_word: word %h sensor %0d rises %0d required 011f sensor 0 rises 16",
                         fr_word[0], fr_sensor[0], fr_rises[0]);
            end
        end
    endtask

    initial begin
        exp_tbl[0] = 16'h011F;
        exp_tbl[1] = 16'h0200;
        exp_tbl[2] = 16'h0304;
        exp_tbl[3] = 16'h0001;
        reset_n = 1'b1;
        spi_if.miso = 1'b0;
        test_reset();
        test_startup();
        test_frames();
        test_done();
        // Run again from reset to exercise a reset landing mid-frame.
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        clear_monitor();
        reset_n = 1'b0;
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
